switch_pipeline_sequencer: RTL and testbench
============================================

# switch_pipeline_sequencer

Per-ingress-port sequencer for the switch allocation pipeline (route compute → VC allocation → switch allocation). It accepts routed head-flit requests, arbitrates round-robin among ingress ports for the single VC-allocator and SA request slots, and tracks each outstanding SA attempt. On SA failure it retries, and after `MAX_SA_RETRIES` failures it releases the VC and re-allocates. It sits between route compute and the VC/switch allocators in the switch top level.

## Interface
Parameters:
- `NUM_BUFFERS`, 5: ingress ports; `INGRESS_SIZE = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1)`.
- `NUM_OUTPORTS`, 5: egress ports; `EGRESS_SIZE` is defined likewise.
- `NUM_VCS`, 2: virtual channels; `VC_SIZE = $clog2(NUM_VCS) + (NUM_VCS == 1)`.
- `MAX_SA_RETRIES`, 3: consecutive SA failures before VC re-allocation, ≥1; `RETRY_SIZE = $clog2(MAX_SA_RETRIES + 1)`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1, `in_ready` out 1: routed-request handshake.
- `in_ingress_port` in `INGRESS_SIZE`, `in_egress_port` in `EGRESS_SIZE`, `in_metadata` in `flit_metadata_t`.
- `vc_req_valid` out 1, `vc_req_ready` in 1: VC request; ready low means no free VC.
- `vc_req_ingress_port`, `vc_req_egress_port`, `vc_req_metadata` out; `vc_gnt_vc` in `VC_SIZE`, sampled on handshake.
- `vc_rel_valid` out 1, `vc_rel_egress_port` out `EGRESS_SIZE`, `vc_rel_vc` out `VC_SIZE`: VC release pulse.
- `sa_valid` out 1, `sa_ready` in 1, `sa_ingress_port`, `sa_egress_port`, `sa_final_vc` out: SA request.
- `pipe_valid` in 1, `pipe_ingress_port` in `INGRESS_SIZE`, `pipe_failed` in 1: SA result.
- `done_valid` out 1, `done_ingress_port` out `INGRESS_SIZE`: success pulse.
- `proto_err` out 1: sticky error; cleared only by `rst`.

## Operation
Each port has its own FSM. The states are `IDLE`, `VC_REQ`, `SA_REQ` and `SA_WAIT`. Each port holds registered `egress`, `metadata`, `vc` and `retry_cnt`.
- `in_ready` is 1 when `state[in_ingress_port] == IDLE` and `rst` is low. A handshake moves the port to `VC_REQ`, latches its fields and clears `retry_cnt`.
- VC arbiter: round-robin over ports in `VC_REQ`. The pointer advances past the winner only on handshake. On handshake the winner latches `vc_gnt_vc` and moves to `SA_REQ`. Without a handshake the winner is held and the request stays asserted with stable fields.
- SA arbiter: an independent round-robin over ports in `SA_REQ`, with the same hold rule. On handshake the winner moves to `SA_WAIT`.
- Result for a port in `SA_WAIT`:
  - Success (`pipe_failed` = 0): `done_valid` pulses next cycle and the port returns to `IDLE`.
  - Failure, `retry_cnt + 1 < MAX_SA_RETRIES`: increment `retry_cnt`, go to `SA_REQ`.
  - Failure, otherwise: `vc_rel_valid` pulses next cycle with the port's egress and VC; clear `retry_cnt`; go to `VC_REQ`.
- `pipe_valid` for a port not in `SA_WAIT` is ignored (no state change) and sets `proto_err`.
- At most one release and one done per cycle, since at most one `pipe_valid` arrives per cycle.

## Timing
- Reset: all ports go to `IDLE`, counters and fields to 0, both RR pointers to 0. All outputs read 0, including `in_ready` while `rst` is high.
- `rst` asserted mid-operation abandons all in-flight state without emitting releases; the VC allocator is reset by the same signal.
- Accept to `vc_req_valid`: 1 cycle minimum. VC grant to `sa_valid`: 1 cycle. `pipe_valid` to `done_valid`/`vc_rel_valid`: 1 cycle (registered). Failure to the new `sa_valid`: 1 cycle.
- The `vc_req_*` and `sa_*` outputs are combinational from registered state and RR pointers. They never depend on `vc_req_ready` or `sa_ready`.
- A same-cycle `pipe_valid` and `in_valid` on one port cannot both be legal: that port is either `IDLE` or `SA_WAIT`.
- Retry counter never wraps: it saturates at `MAX_SA_RETRIES-1` before reset to 0.

## Structure
- `pipe_state_t` enum and the `*_SIZE` formulas go in `switch_pkg`; `flit_metadata_t` comes from `chiplet_types_pkg`.
- Sub-module `rr_arbiter #(N)`: request vector, `advance` input, one-hot grant and index. Instantiated twice (VC, SA).

## Test plan
- Single request, port 2 → egress 4; `vc_req_ready`=1 with grant VC 1; `sa_ready`=1; success `pipe_valid` 3 cycles later → `done_valid` with port 2, then `in_ready` for port 2 returns to 1.
- Ports 0, 1, 3 accepted back-to-back with `vc_req_ready` held 1 → VC grants in order 0, 1, 3. Repeat with pointer at 2 → order 3, 0, 1.
- `MAX_SA_RETRIES`=3, port 1 fails 3 times → two re-issues to SA, then `vc_rel_valid` with egress and VC of port 1, then a new `vc_req_valid` for port 1.
- `vc_req_ready`=0 for 5 cycles → `vc_req_*` held stable, no state change.
- `pipe_valid` for an `IDLE` port 4 → `proto_err`=1 persists, port 4 stays `IDLE`; `rst` clears it.
- `rst` asserted while ports are in `VC_REQ`/`SA_WAIT` → next cycle all outputs 0, all ports `IDLE`, no `vc_rel_valid`.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// Shared flit-level types for the chiplet fabric.
// Provides the head-flit metadata carried alongside routing requests.
package chiplet_types_pkg;

    typedef struct packed {
        logic [1:0] msg_class;
        logic [5:0] pkt_id;
    } flit_metadata_t;

endpackage

// File: rtl/switch_pkg.sv
// Switch-level types and width helpers.
// pipe_state_t is the per-ingress-port sequencer state.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        VC_REQ,
        SA_REQ,
        SA_WAIT
    } pipe_state_t;

    // Index width for n items; a single item still gets one bit.
    function automatic int idx_size(input int n);
        return $clog2(n) + ((n == 1) ? 1 : 0);
    endfunction

    function automatic int retry_size(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/switch_pipeline_sequencer_rr_arbiter.sv
// Round-robin arbiter with grant hold: once a winner is shown it stays
// until advance. Ports: req, advance in; gnt (one-hot), gnt_idx, gnt_valid out.
module rr_arbiter
    import switch_pkg::*;
#(
    parameter int N = 5,
    localparam int IW = idx_size(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    localparam int KW = IW + 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] lock_idx_q;
    logic          lock_q;
    logic [IW-1:0] pick;
    logic          found;
    logic [KW-1:0] k;
    logic          hold;

    // Search from ptr_q upward, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = {1'b0, ptr_q} + KW'(i);
            if (k >= KW'(N)) k = k - KW'(N);
            if (!found && req[k[IW-1:0]]) begin
                found = 1'b1;
                pick  = k[IW-1:0];
            end
        end
    end

    // A shown-but-untaken winner is locked so a newly arriving
    // higher-priority request cannot pull the offer out from under it.
    assign hold      = lock_q && req[lock_idx_q];
    assign gnt_valid = hold || found;
    assign gnt_idx   = hold ? lock_idx_q : pick;
    assign gnt       = gnt_valid ? (N'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (advance) begin
            ptr_q  <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
            lock_q <= 1'b0;
        end else if (gnt_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/switch_pipeline_sequencer.sv
// Per-ingress-port sequencer: route -> VC alloc -> SA, with SA retry and
// VC re-allocation. Ports: in_*, vc_req_*/vc_gnt_vc, vc_rel_*, sa_*, pipe_*, done_*, proto_err.
module switch_pipeline_sequencer
    import switch_pkg::*;
    import chiplet_types_pkg::*;
#(
    parameter int NUM_BUFFERS    = 5,
    parameter int NUM_OUTPORTS   = 5,
    parameter int NUM_VCS        = 2,
    parameter int MAX_SA_RETRIES = 3,
    localparam int INGRESS_SIZE  = idx_size(NUM_BUFFERS),
    localparam int EGRESS_SIZE   = idx_size(NUM_OUTPORTS),
    localparam int VC_SIZE       = idx_size(NUM_VCS),
    localparam int RETRY_SIZE    = retry_size(MAX_SA_RETRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INGRESS_SIZE-1:0] in_ingress_port,
    input  logic [EGRESS_SIZE-1:0]  in_egress_port,
    input  flit_metadata_t          in_metadata,
    output logic                    vc_req_valid,
    input  logic                    vc_req_ready,
    output logic [INGRESS_SIZE-1:0] vc_req_ingress_port,
    output logic [EGRESS_SIZE-1:0]  vc_req_egress_port,
    output flit_metadata_t          vc_req_metadata,
    input  logic [VC_SIZE-1:0]      vc_gnt_vc,
    output logic                    vc_rel_valid,
    output logic [EGRESS_SIZE-1:0]  vc_rel_egress_port,
    output logic [VC_SIZE-1:0]      vc_rel_vc,
    output logic                    sa_valid,
    input  logic                    sa_ready,
    output logic [INGRESS_SIZE-1:0] sa_ingress_port,
    output logic [EGRESS_SIZE-1:0]  sa_egress_port,
    output logic [VC_SIZE-1:0]      sa_final_vc,
    input  logic                    pipe_valid,
    input  logic [INGRESS_SIZE-1:0] pipe_ingress_port,
    input  logic                    pipe_failed,
    output logic                    done_valid,
    output logic [INGRESS_SIZE-1:0] done_ingress_port,
    output logic                    proto_err
);

    localparam int NB = NUM_BUFFERS;

    pipe_state_t            state_q  [NB];
    pipe_state_t            state_d  [NB];
    logic [EGRESS_SIZE-1:0] egress_q [NB];
    logic [EGRESS_SIZE-1:0] egress_d [NB];
    flit_metadata_t         meta_q   [NB];
    flit_metadata_t         meta_d   [NB];
    logic [VC_SIZE-1:0]     vc_q     [NB];
    logic [VC_SIZE-1:0]     vc_d     [NB];
    logic [RETRY_SIZE-1:0]  retry_q  [NB];
    logic [RETRY_SIZE-1:0]  retry_d  [NB];

    logic                    done_d;
    logic [INGRESS_SIZE-1:0] done_port_d;
    logic                    rel_d;
    logic [EGRESS_SIZE-1:0]  rel_egress_d;
    logic [VC_SIZE-1:0]      rel_vc_d;
    logic                    err_d;

    logic [NB-1:0]           vc_req_vec, sa_req_vec;
    logic [NB-1:0]           vc_gnt, sa_gnt;
    logic [INGRESS_SIZE-1:0] vc_idx, sa_idx;
    logic                    vc_any, sa_any;
    logic                    vc_hs, sa_hs;
    logic                    in_ready_c;
    logic                    in_hit, pipe_hit, pipe_legal;

    rr_arbiter #(.N(NB)) u_vc_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (vc_req_vec),
        .advance   (vc_hs),
        .gnt       (vc_gnt),
        .gnt_idx   (vc_idx),
        .gnt_valid (vc_any)
    );

    rr_arbiter #(.N(NB)) u_sa_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (sa_req_vec),
        .advance   (sa_hs),
        .gnt       (sa_gnt),
        .gnt_idx   (sa_idx),
        .gnt_valid (sa_any)
    );

    assign vc_req_valid = vc_any && !rst;
    assign sa_valid     = sa_any && !rst;
    assign vc_hs        = vc_req_valid && vc_req_ready;
    assign sa_hs        = sa_valid && sa_ready;
    assign in_ready     = in_ready_c && !rst;

    // Request vectors and one-hot muxes of the winning port's fields;
    // fields read zero whenever the matching valid is low.
    always_comb begin
        in_ready_c          = 1'b0;
        vc_req_vec          = '0;
        sa_req_vec          = '0;
        vc_req_ingress_port = '0;
        vc_req_egress_port  = '0;
        vc_req_metadata     = '0;
        sa_ingress_port     = '0;
        sa_egress_port      = '0;
        sa_final_vc         = '0;
        for (int p = 0; p < NB; p++) begin
            vc_req_vec[p] = (state_q[p] == VC_REQ);
            sa_req_vec[p] = (state_q[p] == SA_REQ);
            if (in_ingress_port == INGRESS_SIZE'(p) && state_q[p] == IDLE)
                in_ready_c = 1'b1;
            if (vc_req_valid && vc_gnt[p]) begin
                vc_req_ingress_port = vc_idx;
                vc_req_egress_port  = egress_q[p];
                vc_req_metadata     = meta_q[p];
            end
            if (sa_valid && sa_gnt[p]) begin
                sa_ingress_port = sa_idx;
                sa_egress_port  = egress_q[p];
                sa_final_vc     = vc_q[p];
            end
        end
    end

    // Per-port next state. Each port sees at most one event per cycle:
    // accept needs IDLE, grants need VC_REQ/SA_REQ, results need SA_WAIT.
    always_comb begin
        done_d       = 1'b0;
        done_port_d  = '0;
        rel_d        = 1'b0;
        rel_egress_d = '0;
        rel_vc_d     = '0;
        pipe_legal   = 1'b0;
        in_hit       = 1'b0;
        pipe_hit     = 1'b0;
        for (int p = 0; p < NB; p++) begin
            state_d[p]  = state_q[p];
            egress_d[p] = egress_q[p];
            meta_d[p]   = meta_q[p];
            vc_d[p]     = vc_q[p];
            retry_d[p]  = retry_q[p];
            in_hit   = in_valid && in_ready &&
                       (in_ingress_port == INGRESS_SIZE'(p));
            pipe_hit = pipe_valid &&
                       (pipe_ingress_port == INGRESS_SIZE'(p));
            unique case (state_q[p])
                IDLE: begin
                    if (in_hit) begin
                        state_d[p]  = VC_REQ;
                        egress_d[p] = in_egress_port;
                        meta_d[p]   = in_metadata;
                        retry_d[p]  = '0;
                    end
                end
                VC_REQ: begin
                    if (vc_hs && vc_gnt[p]) begin
                        state_d[p] = SA_REQ;
                        vc_d[p]    = vc_gnt_vc;
                    end
                end
                SA_REQ: begin
                    if (sa_hs && sa_gnt[p]) state_d[p] = SA_WAIT;
                end
                SA_WAIT: begin
                    if (pipe_hit) begin
                        pipe_legal = 1'b1;
                        if (!pipe_failed) begin
                            state_d[p]  = IDLE;
                            done_d      = 1'b1;
                            done_port_d = INGRESS_SIZE'(p);
                        end else if (int'(retry_q[p]) + 1 < MAX_SA_RETRIES) begin
                            state_d[p] = SA_REQ;
                            retry_d[p] = retry_q[p] + RETRY_SIZE'(1);
                        end else begin
                            state_d[p]   = VC_REQ;
                            retry_d[p]   = '0;
                            rel_d        = 1'b1;
                            rel_egress_d = egress_q[p];
                            rel_vc_d     = vc_q[p];
                        end
                    end
                end
            endcase
        end
        err_d = proto_err || (pipe_valid && !pipe_legal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NB; p++) begin
                state_q[p]  <= IDLE;
                egress_q[p] <= '0;
                meta_q[p]   <= '0;
                vc_q[p]     <= '0;
                retry_q[p]  <= '0;
            end
            done_valid         <= 1'b0;
            done_ingress_port  <= '0;
            vc_rel_valid       <= 1'b0;
            vc_rel_egress_port <= '0;
            vc_rel_vc          <= '0;
            proto_err          <= 1'b0;
        end else begin
            for (int p = 0; p < NB; p++) begin
                state_q[p]  <= state_d[p];
                egress_q[p] <= egress_d[p];
                meta_q[p]   <= meta_d[p];
                vc_q[p]     <= vc_d[p];
                retry_q[p]  <= retry_d[p];
            end
            done_valid         <= done_d;
            done_ingress_port  <= done_port_d;
            vc_rel_valid       <= rel_d;
            vc_rel_egress_port <= rel_egress_d;
            vc_rel_vc          <= rel_vc_d;
            proto_err          <= err_d;
        end
    end

endmodule

// File: tb/tb_switch_pipeline_sequencer.sv
// Scoreboard bench for switch_pipeline_sequencer: expected VC grants,
// done pulses and releases are queued at stimulus time, popped at output.
module tb_switch_pipeline_sequencer;
    import chiplet_types_pkg::*;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_ingress_port;
    logic [2:0]     in_egress_port;
    flit_metadata_t in_metadata;
    logic           vc_req_valid;
    logic           vc_req_ready;
    logic [2:0]     vc_req_ingress_port;
    logic [2:0]     vc_req_egress_port;
    flit_metadata_t vc_req_metadata;
    logic [0:0]     vc_gnt_vc;
    logic           vc_rel_valid;
    logic [2:0]     vc_rel_egress_port;
    logic [0:0]     vc_rel_vc;
    logic           sa_valid;
    logic           sa_ready;
    logic [2:0]     sa_ingress_port;
    logic [2:0]     sa_egress_port;
    logic [0:0]     sa_final_vc;
    logic           pipe_valid;
    logic [2:0]     pipe_ingress_port;
    logic           pipe_failed;
    logic           done_valid;
    logic [2:0]     done_ingress_port;
    logic           proto_err;

    switch_pipeline_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_ingress_port     (in_ingress_port),
        .in_egress_port      (in_egress_port),
        .in_metadata         (in_metadata),
        .vc_req_valid        (vc_req_valid),
        .vc_req_ready        (vc_req_ready),
        .vc_req_ingress_port (vc_req_ingress_port),
        .vc_req_egress_port  (vc_req_egress_port),
        .vc_req_metadata     (vc_req_metadata),
        .vc_gnt_vc           (vc_gnt_vc),
        .vc_rel_valid        (vc_rel_valid),
        .vc_rel_egress_port  (vc_rel_egress_port),
        .vc_rel_vc           (vc_rel_vc),
        .sa_valid            (sa_valid),
        .sa_ready            (sa_ready),
        .sa_ingress_port     (sa_ingress_port),
        .sa_egress_port      (sa_egress_port),
        .sa_final_vc         (sa_final_vc),
        .pipe_valid          (pipe_valid),
        .pipe_ingress_port   (pipe_ingress_port),
        .pipe_failed         (pipe_failed),
        .done_valid          (done_valid),
        .done_ingress_port   (done_ingress_port),
        .proto_err           (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_pass;
    int n_vc, n_sa, n_done, n_rel;
    int seq;
    int m_eg   [8];
    int m_meta [8];
    int m_vc   [8];
    int exp_vc   [$];
    int exp_done [$];
    int exp_rel  [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        int p;
        if (vc_req_valid && vc_req_ready) begin
            p = int'(vc_req_ingress_port);
            if (exp_vc.size() == 0) chk("vc_unexp", p, 99);
            else chk("vc_port", p, exp_vc.pop_front());
            chk("vc_eg", int'(vc_req_egress_port), m_eg[p]);
            chk("vc_meta", int'(vc_req_metadata), m_meta[p]);
            m_vc[p] = int'(vc_gnt_vc);
            n_vc++;
        end
        if (sa_valid && sa_ready) begin
            p = int'(sa_ingress_port);
            chk("sa_eg", int'(sa_egress_port), m_eg[p]);
            chk("sa_vc", int'(sa_final_vc), m_vc[p]);
            n_sa++;
        end
        if (done_valid) begin
            p = int'(done_ingress_port);
            if (exp_done.size() == 0) chk("done_unexp", p, 99);
            else chk("done_port", p, exp_done.pop_front());
            n_done++;
        end
        if (vc_rel_valid) begin
            p = int'(vc_rel_egress_port) * 16 + int'(vc_rel_vc);
            if (exp_rel.size() == 0) chk("rel_unexp", p, 999);
            else chk("rel_egvc", p, exp_rel.pop_front());
            n_rel++;
        end
    end

    task automatic drive_in(input int p, input int eg);
        flit_metadata_t m;
        seq++;
        m.msg_class = 2'(p);
        m.pkt_id    = 6'(seq);
        in_valid        = 1'b1;
        in_ingress_port = 3'(p);
        in_egress_port  = 3'(eg);
        in_metadata     = m;
        m_eg[p]   = eg;
        m_meta[p] = int'(m);
    endtask

    task automatic accept(input int p, input int eg);
        drive_in(p, eg);
        #1;
        chk("in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pipe(input int p, input bit f);
        pipe_valid        = 1'b1;
        pipe_ingress_port = 3'(p);
        pipe_failed       = f;
        @(posedge clk); #1;
        pipe_valid  = 1'b0;
        pipe_failed = 1'b0;
    endtask

    task automatic wait_ev(input string tag, input int kind, input int target);
        int cnt;
        for (int c = 0; c < 60; c++) begin
            cnt = (kind == 0) ? n_vc : (kind == 1) ? n_sa :
                  (kind == 2) ? n_done : n_rel;
            if (cnt >= target) break;
            @(posedge clk); #1;
        end
        cnt = (kind == 0) ? n_vc : (kind == 1) ? n_sa :
              (kind == 2) ? n_done : n_rel;
        chk(tag, (cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic rr_round(input int blk, input int a, input int b,
                            input int c, input int o0, input int o1,
                            input int o2, input int o3);
        int v0, s0, d0, q;
        vc_req_ready = 1'b0;
        accept(blk, (blk + 2) % 5);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                q = (i == 0) ? a : (i == 1) ? b : c;
                drive_in(q, (q + 1) % 5);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("hold_port", int'(vc_req_ingress_port), blk);
            chk("hold_eg", int'(vc_req_egress_port), m_eg[blk]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        v0 = n_vc; s0 = n_sa; d0 = n_done;
        exp_vc.push_back(o0);
        exp_vc.push_back(o1);
        exp_vc.push_back(o2);
        exp_vc.push_back(o3);
        vc_req_ready = 1'b1;
        wait_ev("rr_vc", 0, v0 + 4);
        wait_ev("rr_sa", 1, s0 + 4);
        exp_done.push_back(o0); pipe(o0, 1'b0);
        exp_done.push_back(o1); pipe(o1, 1'b0);
        exp_done.push_back(o2); pipe(o2, 1'b0);
        exp_done.push_back(o3); pipe(o3, 1'b0);
        wait_ev("rr_done", 2, d0 + 4);
    endtask

    initial begin
        int s0, r0;
        n_chk = 0; n_pass = 0;
        n_vc = 0; n_sa = 0; n_done = 0; n_rel = 0; seq = 0;
        for (int i = 0; i < 8; i++) begin
            m_eg[i] = 0; m_meta[i] = 0; m_vc[i] = 0;
        end
        rst = 1'b1;
        in_valid = 1'b0; in_ingress_port = '0; in_egress_port = '0;
        in_metadata = '0; vc_req_ready = 1'b0; vc_gnt_vc = '0;
        sa_ready = 1'b0; pipe_valid = 1'b0; pipe_ingress_port = '0;
        pipe_failed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_vc_valid", int'(vc_req_valid), 0);
        chk("rst_sa_valid", int'(sa_valid), 0);
        chk("rst_done", int'(done_valid), 0);
        chk("rst_rel", int'(vc_rel_valid), 0);
        chk("rst_err", int'(proto_err), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // single request port 2 -> egress 4, VC 1
        vc_req_ready = 1'b1; sa_ready = 1'b1; vc_gnt_vc = 1'b1;
        exp_vc.push_back(2);
        accept(2, 4);
        chk("t1_vc_lat", int'(vc_req_valid), 1);
        chk("t1_busy", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("t1_sa_lat", int'(sa_valid), 1);
        chk("t1_sa_vc", int'(sa_final_vc), 1);
        @(posedge clk); #1;
        chk("t1_wait", int'(sa_valid), 0);
        @(posedge clk); #1;
        exp_done.push_back(2);
        pipe(2, 1'b0);
        chk("t1_done", int'(done_valid), 1);
        chk("t1_done_port", int'(done_ingress_port), 2);
        chk("t1_idle", int'(in_ready), 1);
        wait_ev("t1_done_ev", 2, 1);

        // back-to-back accepts with VC always ready
        exp_vc.push_back(0); exp_vc.push_back(1); exp_vc.push_back(3);
        accept(0, 1);
        accept(1, 2);
        accept(3, 0);
        wait_ev("b2b_vc", 0, 4);
        wait_ev("b2b_sa", 1, 4);
        exp_done.push_back(0); pipe(0, 1'b0);
        exp_done.push_back(1); pipe(1, 1'b0);
        exp_done.push_back(3); pipe(3, 1'b0);
        wait_ev("b2b_done", 2, 4);

        // round-robin behind a held request
        rr_round(2, 0, 1, 3, 2, 3, 0, 1);
        rr_round(4, 0, 1, 3, 4, 0, 1, 3);

        // SA retries then VC release and re-allocation
        vc_gnt_vc = 1'b0;
        s0 = n_sa; r0 = n_rel;
        exp_vc.push_back(1);
        accept(1, 3);
        wait_ev("rt_sa1", 1, s0 + 1);
        pipe(1, 1'b1);
        chk("rt_resa", int'(sa_valid), 1);
        chk("rt_norel", int'(vc_rel_valid), 0);
        wait_ev("rt_sa2", 1, s0 + 2);
        pipe(1, 1'b1);
        wait_ev("rt_sa3", 1, s0 + 3);
        exp_rel.push_back(3 * 16 + 0);
        exp_vc.push_back(1);
        vc_gnt_vc = 1'b1;
        pipe(1, 1'b1);
        chk("rt_rel", int'(vc_rel_valid), 1);
        chk("rt_rel_eg", int'(vc_rel_egress_port), 3);
        chk("rt_rel_vc", int'(vc_rel_vc), 0);
        chk("rt_revc", int'(vc_req_valid), 1);
        wait_ev("rt_rel_ev", 3, r0 + 1);
        wait_ev("rt_sa4", 1, s0 + 4);
        exp_done.push_back(1);
        pipe(1, 1'b0);
        wait_ev("rt_done", 2, n_done + 1);

        // result for an idle port
        pipe(4, 1'b0);
        chk("pe_set", int'(proto_err), 1);
        in_ingress_port = 3'd4;
        #1;
        chk("pe_idle", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("pe_sticky", int'(proto_err), 1);

        // reset with ports in SA_WAIT and VC_REQ
        vc_gnt_vc = 1'b0;
        s0 = n_sa;
        exp_vc.push_back(0);
        accept(0, 1);
        wait_ev("mr_sa", 1, s0 + 1);
        vc_req_ready = 1'b0;
        accept(3, 2);
        chk("mr_pending", int'(vc_req_valid), 1);
        r0 = n_rel;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_vc_valid", int'(vc_req_valid), 0);
        chk("mr_sa_valid", int'(sa_valid), 0);
        chk("mr_done", int'(done_valid), 0);
        chk("mr_rel", int'(vc_rel_valid), 0);
        chk("mr_err", int'(proto_err), 0);
        chk("mr_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        in_ingress_port = 3'd0;
        #1;
        chk("mr_idle0", int'(in_ready), 1);
        in_ingress_port = 3'd3;
        #1;
        chk("mr_idle3", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("mr_no_rel", n_rel, r0);
        chk("mr_no_vc", int'(vc_req_valid), 0);

        chk("sb_empty", exp_vc.size() + exp_done.size() + exp_rel.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
